// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial_tx byte-serial transmitter.
// SERIAL_TX_PARITY_EN adds an even-parity bit after the data bits.
package serial_tx_pkg;

  localparam int DATA_W = 8;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_tx_if.sv
// Queue read port: master is the transmitter (pops), slave is the queue.
// Handshake: empty=0 means dq is valid; rd=1 pops the head on that rising edge.
interface serial_tx_if;
  import serial_tx_pkg::*;

  logic              empty;
  logic [DATA_W-1:0] dq;
  logic              rd;

  modport master (input empty, input dq, output rd);
  modport slave  (output empty, output dq, input rd);

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic init_n,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cnt <= 16'd0;
    end else if (clear || cnt == LAST) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = ~clear & (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Drains the byte queue and sends start, 8 data bits LSB first, [parity], stop.
// SERIAL_TX_PARITY_EN enables the even-parity bit.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               en,
  serial_tx_if.master        q,
  output logic               txd,
  output logic               busy,
  output state_t             state_dbg
);

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic              txd_n;
  logic              tick;
  logic              load;
`ifdef SERIAL_TX_PARITY_EN
  logic              par, par_n;
`endif

  // Timer is held at zero while idle so START always lasts a full bit.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .init_n (init_n),
    .clear  (state == ST_IDLE),
    .tick   (tick)
  );

  assign load      = en & ~q.empty & ((state == ST_IDLE) | ((state == ST_STOP) & tick));
  assign q.rd      = load;
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
`ifdef SERIAL_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      ST_START: if (tick) state_n = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shreg_n = {1'b0, shreg[DATA_W-1:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
            state_n   = ST_PARITY;
`else
            state_n   = ST_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: if (tick) state_n = ST_STOP;
`endif
      ST_STOP: if (tick) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // A load overrides both the idle hold and the end-of-stop return to idle.
    if (load) begin
      state_n   = ST_START;
      shreg_n   = q.dq;
      bit_idx_n = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
      par_n     = ^q.dq;
`endif
    end

    case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = shreg_n[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: txd_n = par_n;
`endif
      default:   txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
      busy    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
      busy    <= (state_n != ST_IDLE);
`ifdef SERIAL_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a byte queue feeds the DUT and a frame-level model predicts rd/txd/busy.
module tb_serial_tx;
  import serial_tx_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic   clk = 1'b0;
  logic   init_n;
  logic   en;
  logic   txd;
  logic   busy;
  state_t state_dbg;

  serial_tx_if qif ();

  serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .en        (en),
    .q         (qif.master),
    .txd       (txd),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Environment queue and frame-level reference model.
  logic [DATA_W-1:0]     q_bytes[$];
  logic [FRAME_BITS-1:0] frame;
  int                    rem;
  int                    compared;
  int                    mismatched;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void drive_q();
    qif.empty = (q_bytes.size() == 0);
    qif.dq    = (q_bytes.size() == 0) ? 8'h00 : q_bytes[0];
  endfunction

  // Bits in time order: index 0 is the start bit, last index is the stop bit.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_W-1:0] b);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic step();
    logic exp_rd;
    logic exp_txd;
    @(negedge clk);
    exp_txd = (rem > 0) ? frame[(FRAME_CYC - rem) / CPB] : 1'b1;
    exp_rd  = en && (q_bytes.size() > 0) && (rem == 0 || rem == 1);
    check("rd",   32'(qif.rd), 32'(exp_rd));
    check("txd",  32'(txd),    32'(exp_txd));
    check("busy", 32'(busy),   32'(rem > 0));
    @(posedge clk);
    if (exp_rd) begin
      frame = make_frame(q_bytes.pop_front());
      rem   = FRAME_CYC;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
    drive_q();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    q_bytes.push_back(b);
    drive_q();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rem        = 0;
    frame      = '1;
    en         = 1'b1;
    init_n     = 1'b0;
    drive_q();

    // Reset values while held in reset.
    #12;
    check("rst_txd",   32'(txd),       32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_rd",    32'(qif.rd),    32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #1 init_n = 1'b1;

    // Idle with an empty queue.
    run(200);

    // Single byte, then a back-to-back burst.
    push(8'hA5);
    run(FRAME_CYC + 10);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    run(3 * FRAME_CYC + 10);

    // Flow control: hold off, start, then drop en mid-frame.
    en = 1'b0;
    push(8'h3C);
    run(30);
    en = 1'b1;
    run(10);
    en = 1'b0;
    push(8'h96);
    run(FRAME_CYC + 20);
    en = 1'b1;
    run(FRAME_CYC + 10);

    // Asynchronous reset during data bit 4 of 0xFF.
    push(8'hFF);
    run(1 + CPB + 4 * CPB + 2);
    #2 init_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(txd),       32'd1);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    q_bytes.delete();
    rem = 0;
    drive_q();
    repeat (3) @(posedge clk);
    #1 init_n = 1'b1;
    run(50);

`ifdef SERIAL_TX_PARITY_EN
    push(8'h07);
    run(FRAME_CYC + 5);
    push(8'h03);
    run(FRAME_CYC + 5);
`endif

    // Random traffic with occasional en toggles, then drain.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0 && q_bytes.size() < 16)
        q_bytes.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 199) == 0)
        en = ~en;
      drive_q();
      step();
    end
    en = 1'b1;
    run(17 * FRAME_CYC + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-serial transmitter that drains the 16-entry ring-buffer queue and shifts each byte out on a single line as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, stop bit. It sits directly downstream of the queue, driving the queue's RD input and consuming its DQ/EMPTY outputs. Pops are issued only when the transmitter is ready for a new byte, so the queue absorbs bursts from the producer.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- CLK  in  1  system clock; all state changes on the rising edge.
- INIT_N  in  1  reset, asynchronous, active-low; one clock domain only.
- EN  in  1  1 = allowed to start new frames; 0 = finish the current frame, then hold idle.
- EMPTY  in  1  queue empty flag.
- DQ  in  8  queue head data; valid whenever EMPTY=0.
- RD  out  1  pop strobe to the queue; combinational, at most one cycle per frame.
- TXD  out  1  serial line; idles high.
- BUSY  out  1  1 while a frame is in progress, START through STOP.

## Operation
- Reset values: TXD=1, BUSY=0, RD=0, state IDLE, bit timer 0, bit index 0, shift register 0x00.
- States:
  - IDLE -> START, START -> DATA, DATA -> PARITY (only with parity) or STOP, STOP -> START or IDLE.
  - Each state except IDLE lasts exactly CLKS_PER_BIT cycles.
- Load condition: RD = EN & ~EMPTY & (state==IDLE | (state==STOP & last cycle of bit)).
  - On the edge where RD=1, DQ is latched into the shift register and the state becomes START.
  - The queue pops on that same edge.
- Data bits:
  - TXD = shreg[0]; the register shifts right once per bit time.
  - Bit index counts 0..7 and moves to the next state after index 7.
- TXD per state: START=0, STOP=1, IDLE=1.
- RD is never asserted while EMPTY=1, and never more than once per frame.
- EN is sampled only at load decisions. Deasserting EN mid-frame does not truncate the frame.
- Back-to-back frames: when the queue is non-empty at the end of STOP, the next START follows with zero idle cycles.
- Reset mid-frame: TXD returns to 1 immediately. A byte already popped is discarded, not re-sent.
- Bit timer is 16 bits, counts 0..CLKS_PER_BIT-1, wraps to 0 and advances the state.

## Timing
- Latency: EMPTY falls in cycle n while IDLE and EN=1. RD=1 in cycle n. TXD=0 from cycle n+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- BUSY rises in cycle n+1 and falls the cycle after STOP ends, unless a back-to-back load occurs, in which case it stays high.
- Throughput: one byte per frame length at sustained non-empty queue.
- All outputs except RD are registered.

## Configuration
- SERIAL_TX_PARITY_EN defined:
  - PARITY state inserted after DATA.
  - TXD = ^byte, i.e. even parity: a byte with an odd number of ones sends 1.
  - Frame is 11 bit times.
- SERIAL_TX_PARITY_EN undefined:
  - No PARITY state or parity logic.
  - DATA goes straight to STOP; frame is 10 bit times.

## Structure
- Package serial_tx_pkg:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit).
  - DATA_W=8 and FRAME_BITS, the latter derived from SERIAL_TX_PARITY_EN.
- Sub-module bit_timer:
  - inputs CLK, INIT_N, clear; output tick on the last cycle of each bit.
  - parameter CLKS_PER_BIT.
- Top level holds the FSM, shift register and bit index.

## Test plan
- Reset then idle: INIT_N=0 pulse, EMPTY=1, EN=1 for 200 cycles -> TXD=1, RD=0, BUSY=0 throughout.
- Single byte, CLKS_PER_BIT=4, parity off: EMPTY=0 with DQ=0xA5 for one pop -> exactly one RD pulse; TXD = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles to idle.
- Back-to-back: queue preloaded with 0x01,0x02,0x03 -> three RD pulses spaced exactly 40 cycles apart, no idle gap, bytes sent in order.
- Flow control: EN=0 with EMPTY=0 -> no RD, TXD=1. EN dropped mid-frame -> frame completes, no further RD.
- Reset mid-frame: INIT_N low at bit 4 of 0xFF -> TXD=1 asynchronously. After release with EMPTY=1 -> no RD, stays idle.
- Parity build (SERIAL_TX_PARITY_EN): DQ=0x07 -> parity bit 1, frame 44 cycles. DQ=0x03 -> parity bit 0.
